// File: rtl/bp_be_stride_detector_pkg.sv
// Shared types for the stride detector: table entry layout, FSM states, stride sign-extension.
package bp_be_stride_detector_pkg;

    localparam int sd_vaddr_width_gp  = 39;
    localparam int sd_stride_width_gp = 16;
    localparam int sd_conf_width_gp   = 2;

    typedef struct packed {
        logic                                 v;
        logic [sd_vaddr_width_gp-1:0]         pc;
        logic [sd_vaddr_width_gp-1:0]         last_addr;
        logic signed [sd_stride_width_gp-1:0] stride;
        logic [sd_conf_width_gp-1:0]          conf;
    } sd_entry_s;

    typedef enum logic [1:0] {
        e_sd_idle,
        e_sd_discover,
        e_sd_wait_est,
        e_sd_prefetch
    } sd_state_e;

    function automatic logic [sd_vaddr_width_gp-1:0] sext_stride(input logic [sd_stride_width_gp-1:0] s);
        return {{(sd_vaddr_width_gp-sd_stride_width_gp){s[sd_stride_width_gp-1]}}, s};
    endfunction

endpackage

// File: rtl/bp_be_stride_table.sv
// Stride table: PC-tagged CAM with round-robin allocation and saturating confidence.
// Latency: one lookup per committed load, update visible the following cycle.
// Backpressure: none; every committed load is absorbed.
module bp_be_stride_table
    import bp_be_stride_detector_pkg::*;
#(
    parameter int table_entries_p = 4
)(
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                load_v_i,
    input  logic [sd_vaddr_width_gp-1:0]        load_pc_i,
    input  logic [sd_vaddr_width_gp-1:0]        load_eaddr_i,
    input  logic [$clog2(table_entries_p)-1:0]  rd_idx_i,
    output sd_entry_s                           rd_entry_o,
    output logic                                trig_v_o,
    output logic [$clog2(table_entries_p)-1:0]  trig_idx_o,
    output logic [sd_vaddr_width_gp-1:0]        trig_pc_o
);

    localparam int idx_w_lp = $clog2(table_entries_p);
    localparam int vw_lp    = sd_vaddr_width_gp;
    localparam int sw_lp    = sd_stride_width_gp;

    sd_entry_s             tbl_r [table_entries_p];
    logic [idx_w_lp-1:0]   rr_ptr_r;
    logic                  hit_v;
    logic [idx_w_lp-1:0]   hit_idx;
    logic [vw_lp-1:0]      delta;
    logic                  delta_fits;
    logic                  stride_match;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit_v      = 1'b0;
        hit_idx    = '0;
        trig_v_o   = 1'b0;
        trig_idx_o = '0;
        for (int i = table_entries_p-1; i >= 0; i--) begin
            if (tbl_r[i].v && (tbl_r[i].pc == load_pc_i)) begin
                hit_v   = 1'b1;
                hit_idx = idx_w_lp'(i);
            end
            if (tbl_r[i].v && (tbl_r[i].conf == sd_conf_width_gp'(1))) begin
                trig_v_o   = 1'b1;
                trig_idx_o = idx_w_lp'(i);
            end
        end
    end

    assign rd_entry_o = tbl_r[rd_idx_i];
    assign trig_pc_o  = tbl_r[trig_idx_o].pc;

    // A delta only counts if it survives the round trip through the narrow stride field.
    assign delta        = load_eaddr_i - tbl_r[hit_idx].last_addr;
    assign delta_fits   = (delta[vw_lp-1:sw_lp-1] == '0) || (delta[vw_lp-1:sw_lp-1] == '1);
    assign stride_match = delta_fits && (delta[sw_lp-1:0] == tbl_r[hit_idx].stride) && (delta != '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < table_entries_p; i++) begin
                tbl_r[i] <= '0;
            end
            rr_ptr_r <= '0;
        end else if (load_v_i) begin
            if (hit_v) begin
                tbl_r[hit_idx].last_addr <= load_eaddr_i;
                if (stride_match) begin
                    if (tbl_r[hit_idx].conf != '1) begin
                        tbl_r[hit_idx].conf <= tbl_r[hit_idx].conf + 1'b1;
                    end
                end else begin
                    tbl_r[hit_idx].stride <= delta[sw_lp-1:0];
                    tbl_r[hit_idx].conf   <= '0;
                end
            end else begin
                tbl_r[rr_ptr_r] <= '{v: 1'b1, pc: load_pc_i, last_addr: load_eaddr_i, stride: '0, conf: '0};
                rr_ptr_r        <= rr_ptr_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Striding-load detector: drives loop discovery, takes the iteration estimate, emits a prefetch burst.
// Latency: start/confirm pulses one cycle after the table shows the condition; first prefetch one cycle after yumi.
// Backpressure: yumi_o mirrors v_i in WAIT_EST; pf_v_o/pf_addr_o hold until pf_ready_i.
module bp_be_stride_detector
    import bp_be_stride_detector_pkg::*;
#(
    parameter int table_entries_p     = 4,
    parameter int confirm_threshold_p = 3,
    parameter int output_range_p      = 8,
    parameter int max_prefetch_p      = 16,
    parameter int discovery_timeout_p = 256
)(
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          load_v_i,
    input  logic [sd_vaddr_width_gp-1:0]  load_pc_i,
    input  logic [sd_vaddr_width_gp-1:0]  load_eaddr_i,
    output logic                          start_discovery_o,
    output logic                          confirm_discovery_o,
    output logic [sd_vaddr_width_gp-1:0]  striding_pc_o,
    input  logic [output_range_p-1:0]     remaining_iterations_i,
    input  logic                          v_i,
    output logic                          yumi_o,
    output logic                          pf_v_o,
    output logic [sd_vaddr_width_gp-1:0]  pf_addr_o,
    input  logic                          pf_ready_i,
    output logic                          busy_o
);

    localparam int idx_w_lp   = $clog2(table_entries_p);
    localparam int timer_w_lp = $clog2(discovery_timeout_p);
    localparam int cnt_w_lp   = $clog2(max_prefetch_p+1);

    sd_state_e                         state_r, state_n;
    logic [idx_w_lp-1:0]               idx_r;
    logic [timer_w_lp-1:0]             timer_r;
    logic [cnt_w_lp-1:0]               cnt_r;
    logic [sd_stride_width_gp-1:0]     stride_r;
    sd_entry_s                         trk;
    logic                              trig_v;
    logic [idx_w_lp-1:0]               trig_idx;
    logic [sd_vaddr_width_gp-1:0]      trig_pc;
    logic [cnt_w_lp-1:0]               est_cnt;
    logic                              start_n, confirm_n, pf_hs, lost;

    bp_be_stride_table #(.table_entries_p(table_entries_p)) u_table (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_v_i    (load_v_i),
        .load_pc_i   (load_pc_i),
        .load_eaddr_i(load_eaddr_i),
        .rd_idx_i    (idx_r),
        .rd_entry_o  (trk),
        .trig_v_o    (trig_v),
        .trig_idx_o  (trig_idx),
        .trig_pc_o   (trig_pc)
    );

    assign est_cnt = (int'(remaining_iterations_i) > max_prefetch_p) ? cnt_w_lp'(max_prefetch_p)
                                                                     : cnt_w_lp'(remaining_iterations_i);
    assign pf_hs   = pf_v_o & pf_ready_i;
    assign busy_o  = (state_r != e_sd_idle);
    // The tracked slot may have been recycled for another PC while we were discovering.
    assign lost    = !trk.v || (trk.pc != striding_pc_o) || (trk.conf == '0)
                   || (timer_r == timer_w_lp'(discovery_timeout_p-1));

    always_comb begin
        state_n   = state_r;
        start_n   = 1'b0;
        confirm_n = 1'b0;
        yumi_o    = 1'b0;
        case (state_r)
            e_sd_idle: begin
                if (trig_v) begin
                    state_n = e_sd_discover;
                    start_n = 1'b1;
                end
            end
            e_sd_discover: begin
                if (trk.conf >= sd_conf_width_gp'(confirm_threshold_p)) begin
                    state_n   = e_sd_wait_est;
                    confirm_n = 1'b1;
                end else if (lost) begin
                    state_n = e_sd_idle;
                end
            end
            e_sd_wait_est: begin
                yumi_o = v_i;
                if (v_i) begin
                    state_n = (est_cnt == '0) ? e_sd_idle : e_sd_prefetch;
                end
            end
            e_sd_prefetch: begin
                if (pf_hs && (cnt_r == cnt_w_lp'(1))) begin
                    state_n = e_sd_idle;
                end
            end
            default: state_n = e_sd_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r             <= e_sd_idle;
            idx_r               <= '0;
            timer_r             <= '0;
            cnt_r               <= '0;
            stride_r            <= '0;
            start_discovery_o   <= 1'b0;
            confirm_discovery_o <= 1'b0;
            striding_pc_o       <= '0;
            pf_v_o              <= 1'b0;
            pf_addr_o           <= '0;
        end else begin
            state_r             <= state_n;
            start_discovery_o   <= start_n;
            confirm_discovery_o <= confirm_n;
            if (start_n) begin
                idx_r         <= trig_idx;
                striding_pc_o <= trig_pc;
                timer_r       <= '0;
            end else if (state_n == e_sd_idle) begin
                striding_pc_o <= '0;
            end
            if (state_r == e_sd_discover) begin
                timer_r <= timer_r + 1'b1;
            end
            // Stride is frozen at burst start so later table updates cannot bend the burst.
            if ((state_r == e_sd_wait_est) && v_i) begin
                cnt_r     <= est_cnt;
                stride_r  <= trk.stride;
                pf_addr_o <= trk.last_addr + sext_stride(trk.stride);
                pf_v_o    <= (est_cnt != '0);
            end
            if ((state_r == e_sd_prefetch) && pf_hs) begin
                cnt_r     <= cnt_r - 1'b1;
                pf_addr_o <= pf_addr_o + sext_stride(stride_r);
                if (cnt_r == cnt_w_lp'(1)) begin
                    pf_v_o <= 1'b0;
                end
            end
        end
    end

endmodule
